// File: rtl/prime_batch_feeder.sv
// prime_batch_feeder: buffers 8-bit candidates in a small FIFO and drives the
// primality core (N/Start out, Salida in) with fixed timing, since the core has
// no done flag. Each job yields a one-cycle tagged result and a running prime count.
//
// Ports:
//   Clk, Rst            clock, asynchronous active-high reset
//   In_Valid/In_Data    candidate offer; In_Ready = FIFO not full
//   N, Start            operand and start strobe to the core (registered)
//   Salida              core result, 1 = prime
//   Res_Valid/Res_N/Res_Prime  one-cycle result strobe with tag and primality
//   Prime_Count         saturating count of prime results since reset
//   Busy                high in every state except IDLE
module prime_batch_feeder #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned WAIT_CYCLES = 600,
  parameter int unsigned START_LEN   = 2
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       In_Valid,
  input  logic [7:0] In_Data,
  output logic       In_Ready,
  output logic [7:0] N,
  output logic       Start,
  input  logic       Salida,
  output logic       Res_Valid,
  output logic [7:0] Res_N,
  output logic       Res_Prime,
  output logic [7:0] Prime_Count,
  output logic       Busy
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned WCNT_W = $clog2(WAIT_CYCLES + 1);
  localparam int unsigned PCNT_W = $clog2(START_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PULSE,
    S_WAIT,
    S_CAPTURE
  } state_t;

  state_t            r_state;
  logic [7:0]        r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [PCNT_W-1:0] r_pulse_cnt;
  logic [WCNT_W-1:0] r_wait_cnt;
  logic              r_salida;
  logic [7:0]        r_n;
  logic              r_start;
  logic              r_res_valid;
  logic [7:0]        r_res_n;
  logic              r_res_prime;
  logic [7:0]        r_prime_count;
  logic              r_busy;

  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic [7:0]        w_head;

  // Ready comes from the registered count, so a pop while full only frees a
  // slot from the following cycle on.
  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign w_push   = In_Valid && !w_full;
  assign w_pop    = (r_state == S_IDLE) && (r_count != '0);
  assign w_head   = r_mem[r_rd_ptr];
  assign In_Ready = !w_full;

  // FIFO storage
  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= In_Data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is a power of two)
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Job sequencer toward the core
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state       <= S_IDLE;
      r_pulse_cnt   <= '0;
      r_wait_cnt    <= '0;
      r_salida      <= 1'b0;
      r_n           <= '0;
      r_start       <= 1'b0;
      r_res_valid   <= 1'b0;
      r_res_n       <= '0;
      r_res_prime   <= 1'b0;
      r_prime_count <= '0;
      r_busy        <= 1'b0;
    end else begin
      r_res_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_n     <= w_head;
            r_busy  <= 1'b1;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          // N has had one setup cycle; raise Start for START_LEN cycles
          r_start     <= 1'b1;
          r_pulse_cnt <= PCNT_W'(START_LEN);
          r_state     <= S_PULSE;
        end
        S_PULSE: begin
          r_pulse_cnt <= r_pulse_cnt - PCNT_W'(1);
          if (r_pulse_cnt == PCNT_W'(1)) begin
            r_start    <= 1'b0;
            r_wait_cnt <= WCNT_W'(WAIT_CYCLES);
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Leaving as the counter steps to zero gives exactly WAIT_CYCLES cycles here
          r_wait_cnt <= r_wait_cnt - WCNT_W'(1);
          if (r_wait_cnt == WCNT_W'(1)) begin
            r_salida <= Salida;
            r_state  <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          r_res_valid <= 1'b1;
          r_res_n     <= r_n;
          r_res_prime <= r_salida;
          if (r_salida && (r_prime_count != 8'hFF)) begin
            r_prime_count <= r_prime_count + 8'd1;
          end
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_start <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign N           = r_n;
  assign Start       = r_start;
  assign Res_Valid   = r_res_valid;
  assign Res_N       = r_res_n;
  assign Res_Prime   = r_res_prime;
  assign Prime_Count = r_prime_count;
  assign Busy        = r_busy;

endmodule

// File: tb/tb_prime_batch_feeder.sv
// Testbench for prime_batch_feeder: a timed core model answers Salida only once
// the compute window has elapsed; results are checked in order against a queue
// of accepted candidates, a trial-division primality model and a saturating count.
module tb_prime_batch_feeder;

  localparam int DEPTH = 4;
  localparam int WC    = 8;
  localparam int SL    = 2;
  localparam int JOB   = SL + WC + 3;
  localparam int LAT   = 1 + SL + WC + 1;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       In_Valid = 1'b0;
  logic [7:0] In_Data = 8'd0;
  logic       In_Ready;
  logic [7:0] N;
  logic       Start;
  logic       Salida;
  logic       Res_Valid;
  logic [7:0] Res_N;
  logic       Res_Prime;
  logic [7:0] Prime_Count;
  logic       Busy;

  prime_batch_feeder #(
    .DEPTH      (DEPTH),
    .WAIT_CYCLES(WC),
    .START_LEN  (SL)
  ) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .In_Valid   (In_Valid),
    .In_Data    (In_Data),
    .In_Ready   (In_Ready),
    .N          (N),
    .Start      (Start),
    .Salida     (Salida),
    .Res_Valid  (Res_Valid),
    .Res_N      (Res_N),
    .Res_Prime  (Res_Prime),
    .Prime_Count(Prime_Count),
    .Busy       (Busy)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  function automatic logic is_prime(input logic [7:0] v);
    int x;
    x = int'(v);
    if (x < 2) return 1'b0;
    for (int d = 2; d * d <= x; d++) begin
      if (x % d == 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Core model: answer becomes valid WC cycles after Start falls, 0 before that
  int         core_cnt = WC;
  logic [7:0] core_n = 8'd0;
  always @(posedge Clk) begin
    if (Start) begin
      core_cnt <= 0;
      core_n   <= N;
    end else if (core_cnt < WC) begin
      core_cnt <= core_cnt + 1;
    end
  end
  assign Salida = (core_cnt >= WC - 1) ? is_prime(core_n) : 1'b0;

  // Output monitor
  logic [7:0] obs_n[$];
  logic       obs_p[$];
  logic [7:0] obs_c[$];
  int         obs_cyc[$];
  int         start_cnt = 0;
  logic [7:0] start_n = 8'd0;
  always @(negedge Clk) begin
    if (Res_Valid) begin
      obs_n.push_back(Res_N);
      obs_p.push_back(Res_Prime);
      obs_c.push_back(Prime_Count);
      obs_cyc.push_back(cyc);
    end
    if (Start) begin
      start_cnt <= start_cnt + 1;
      start_n   <= N;
    end
  end

  // Reference model state
  logic [7:0] exp_q[$];
  int model_cnt = 0;
  int rd = 0;
  int last_push_cyc = 0;
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic push(input logic [7:0] v);
    int t;
    t = 0;
    In_Valid = 1'b1;
    In_Data  = v;
    while (!In_Ready && t < 200) begin
      @(negedge Clk);
      t++;
    end
    check("push_ready", 32'(In_Ready), 32'd1);
    @(negedge Clk);
    last_push_cyc = cyc;
    exp_q.push_back(v);
    In_Valid = 1'b0;
  endtask

  task automatic check_results(input int n, input string tag);
    int t;
    logic [7:0] v;
    logic p;
    t = 0;
    while (obs_n.size() < rd + n && t < n * JOB + 100) begin
      @(negedge Clk);
      t++;
    end
    check({tag, "_arrived"}, 32'(obs_n.size() >= rd + n), 32'd1);
    for (int i = 0; i < n; i++) begin
      if (rd < obs_n.size() && exp_q.size() > 0) begin
        v = exp_q.pop_front();
        p = is_prime(v);
        if (p && model_cnt < 255) model_cnt++;
        check({tag, "_res_n"}, 32'(obs_n[rd]), 32'(v));
        check({tag, "_res_prime"}, 32'(obs_p[rd]), 32'(p));
        check({tag, "_prime_count"}, 32'(obs_c[rd]), 32'(model_cnt));
        if (i > 0) check({tag, "_gap"}, 32'(obs_cyc[rd] - obs_cyc[rd-1]), 32'(JOB));
        rd++;
      end
    end
    repeat (JOB + 5) @(negedge Clk);
    check({tag, "_no_extra"}, 32'(obs_n.size()), 32'(rd));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, s0, t0, need, res_before;
    logic [7:0] v;
    logic [7:0] batch [5];
    batch[0] = 8'd4; batch[1] = 8'd5; batch[2] = 8'd6; batch[3] = 8'd7; batch[4] = 8'd11;

    // Reset release with no input
    repeat (3) @(negedge Clk);
    Rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge Clk);
      check("reset_idle", 32'({N, Start, Res_Valid, Res_N, Res_Prime, Prime_Count, Busy, In_Ready}), 32'd1);
    end

    // Single job
    s0 = start_cnt;
    push(8'd7);
    p0 = last_push_cyc;
    check_results(1, "single");
    if (rd > 0) check("single_latency", 32'(obs_cyc[rd-1] - p0), 32'(1 + LAT));
    check("single_start_len", 32'(start_cnt - s0), 32'(SL));
    check("single_start_n", 32'(start_n), 32'd7);
    check("single_n_hold", 32'(N), 32'd7);
    check("single_count", 32'(Prime_Count), 32'd1);

    // Back-to-back fill; 4 pops at once, 5/6/7/11 fill the FIFO
    s0 = start_cnt;
    push(batch[0]);
    p0 = last_push_cyc;
    for (int i = 1; i < 5; i++) push(batch[i]);
    check("full_ready_low", 32'(In_Ready), 32'd0);
    repeat (3) begin
      if (!In_Ready) begin
        In_Valid = 1'b1;
        In_Data  = 8'hEE;
      end else begin
        In_Valid = 1'b0;
      end
      @(negedge Clk);
    end
    In_Valid = 1'b0;
    t0 = cyc;
    push(8'd13);
    check("stall_accept", 32'(last_push_cyc - p0), 32'(1 + JOB + 1));
    check("stall_waited", 32'(last_push_cyc - t0 > 3), 32'd1);
    check_results(6, "batch");
    check("batch_count", 32'(Prime_Count), 32'd5);
    check("batch_start_len", 32'(start_cnt - s0), 32'(6 * SL));

    // Random candidates
    repeat (20) push(8'($urandom_range(0, 255)));
    check_results(20, "rand");

    // Saturation: enough primes to reach 255, then one more
    need = 256 - model_cnt;
    for (int i = 0; i < need; i++) begin
      do v = 8'($urandom_range(2, 255)); while (!is_prime(v));
      push(v);
    end
    check_results(need, "sat");
    check("sat_count", 32'(Prime_Count), 32'd255);

    // Reset during WAIT with two entries queued
    push(8'd40);
    p0 = last_push_cyc;
    push(8'd41);
    push(8'd43);
    while (cyc < p0 + 7) @(negedge Clk);
    check("pre_rst_busy", 32'(Busy), 32'd1);
    check("pre_rst_start", 32'(Start), 32'd0);
    res_before = obs_n.size();
    Rst = 1'b1;
    #1;
    check("rst_async", 32'({Start, Busy, In_Ready, N, Res_Valid, Prime_Count}), 32'({1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 8'd0}));
    repeat (3) @(negedge Clk);
    Rst = 1'b0;
    exp_q.delete();
    model_cnt = 0;
    repeat (40) @(negedge Clk);
    check("rst_no_result", 32'(obs_n.size()), 32'(res_before));
    check("rst_fifo_empty_busy", 32'(Busy), 32'd0);
    check("rst_fifo_empty_ready", 32'(In_Ready), 32'd1);
    rd = obs_n.size();
    push(8'd13);
    check_results(1, "post_rst");
    check("post_rst_count", 32'(Prime_Count), 32'd1);

    // Push coinciding with the IDLE pop at count=1
    push(8'd20);
    p0 = last_push_cyc;
    push(8'd23);
    while (cyc < p0 + JOB) @(negedge Clk);
    push(8'd29);
    check("simul_accept", 32'(last_push_cyc - p0), 32'(JOB + 1));
    push(8'd30);
    push(8'd31);
    push(8'd37);
    check("simul_full", 32'(In_Ready), 32'd0);
    check_results(6, "simul");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
